rtc_reg_bank: RTL and testbench

Parametrised capture-and-scan register bank between the RTC bus read engine and the VGA text renderer. It collects a burst of NUM_REGS words from the read engine into a shadow bank and commits them atomically to a visible bank. It presents the visible bank both as a flat parallel bus and as a repeating serial scan, with a frame marker and a programmable inter-frame gap. It replaces the fixed 11-byte, counter-decoded register set and its tri-state readout mux.

---
 rtl/rtc_bank_pkg.sv | 22 ++
 rtl/reg_bank_scan_seq.sv | 67 ++++++
 rtl/rtc_reg_bank.sv | 137 +++++++++++++
 tb/tb_rtc_reg_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rtc_bank_pkg.sv
// rtl/rtc_bank_pkg.sv - shared types, defaults and index-width helper for the RTC register bank
package rtc_bank_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 11;

  typedef enum logic [1:0] {
    CAP_IDLE   = 2'd0,
    CAP_CAPT   = 2'd1,
    CAP_COMMIT = 2'd2
  } cap_state_e;

  typedef enum logic {
    SCN_GAP  = 1'b0,
    SCN_SCAN = 1'b1
  } scan_state_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_bank_scan_seq.sv
// rtl/reg_bank_scan_seq.sv - free-running GAP/SCAN sequencer with registered bank read mux
module reg_bank_scan_seq
  import rtc_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SCAN_GAP = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REGS*DATA_W-1:0] bank_flat,
  output logic [DATA_W-1:0]          scan_data,
  output logic [idx_w(NUM_REGS)-1:0] scan_idx,
  output logic                       scan_valid,
  output logic                       scan_frame
);

  localparam int IW = idx_w(NUM_REGS);
  localparam int CW = idx_w(SCAN_GAP + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  scan_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (state_q == SCN_GAP) begin
      if (cnt_q == CW'(1)) begin
        state_d = SCN_SCAN;
        idx_d   = '0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (idx_q == LAST_IDX) begin
      state_d = SCN_GAP;
      cnt_d   = CW'(SCAN_GAP);
      idx_d   = '0;
    end else begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Read the bank as it stands before this edge, so a commit shows from the next word on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCN_GAP;
      cnt_q   <= CW'(SCAN_GAP);
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= (state_d == SCN_SCAN) ? bank_flat[idx_d*DATA_W +: DATA_W] : '0;
    end
  end

  assign scan_data  = data_q;
  assign scan_idx   = idx_q;
  assign scan_valid = (state_q == SCN_SCAN);
  assign scan_frame = (state_q == SCN_SCAN) && (idx_q == '0);

endmodule

// File: rtl/rtc_reg_bank.sv
// rtl/rtc_reg_bank.sv - burst capture into shadow bank, atomic commit, optional scan (REG_BANK_SCAN_EN)
module rtc_reg_bank
  import rtc_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SCAN_GAP = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       burst_start,
  input  logic                       burst_abort,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       data_valid,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       bank_valid,
  output logic                       commit_pulse,
  output logic                       busy,
  output logic                       overflow,
  output logic [DATA_W-1:0]          scan_data,
  output logic [idx_w(NUM_REGS)-1:0] scan_idx,
  output logic                       scan_valid,
  output logic                       scan_frame
);

  localparam int IW = idx_w(NUM_REGS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

  if (NUM_REGS < 2 || SCAN_GAP < 1) begin : g_param_check
    $error("rtc_reg_bank: NUM_REGS must be >= 2 and SCAN_GAP >= 1");
  end

  cap_state_e        state_q, state_d;
  logic [IW-1:0]     wr_idx_q, wr_idx_d;
  logic              overflow_q, overflow_d;
  logic              bank_valid_q;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] bank_q   [NUM_REGS];
  logic              shadow_we;
  logic [IW-1:0]     shadow_addr;
  logic              commit;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    overflow_d  = overflow_q;
    shadow_we   = 1'b0;
    shadow_addr = wr_idx_q;
    commit      = 1'b0;
    if (burst_abort) begin
      state_d  = CAP_IDLE;
      wr_idx_d = '0;
    end else begin
      // A pending commit completes even when a new burst opens in the same cycle.
      commit = (state_q == CAP_COMMIT);
      if (burst_start) begin
        state_d     = CAP_CAPT;
        overflow_d  = 1'b0;
        shadow_addr = '0;
        shadow_we   = data_valid;
        wr_idx_d    = data_valid ? IW'(1) : '0;
      end else begin
        case (state_q)
          CAP_CAPT: begin
            if (data_valid) begin
              shadow_we = 1'b1;
              if (wr_idx_q == LAST_IDX) begin
                state_d  = CAP_COMMIT;
                wr_idx_d = '0;
              end else begin
                wr_idx_d = wr_idx_q + 1'b1;
              end
            end
          end
          CAP_COMMIT: begin
            state_d = CAP_IDLE;
            if (data_valid) overflow_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CAP_IDLE;
      wr_idx_q     <= '0;
      overflow_q   <= 1'b0;
      bank_valid_q <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= '0;
        bank_q[k]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      overflow_q <= overflow_d;
      if (shadow_we) shadow_q[shadow_addr] <= data_in;
      if (commit) begin
        bank_q       <= shadow_q;
        bank_valid_q <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[k*DATA_W +: DATA_W] = bank_q[k];
  end

  assign bank_valid   = bank_valid_q;
  assign commit_pulse = (state_q == CAP_COMMIT);
  assign busy         = (state_q != CAP_IDLE);
  assign overflow     = overflow_q;

`ifdef REG_BANK_SCAN_EN
  reg_bank_scan_seq #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .SCAN_GAP (SCAN_GAP)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .bank_flat  (regs_flat),
    .scan_data  (scan_data),
    .scan_idx   (scan_idx),
    .scan_valid (scan_valid),
    .scan_frame (scan_frame)
  );
`else
  assign scan_data  = '0;
  assign scan_idx   = '0;
  assign scan_valid = 1'b0;
  assign scan_frame = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_reg_bank.sv
// tb/tb_rtc_reg_bank.sv - scoreboard bench for rtc_reg_bank with a behavioural bank model
module tb_rtc_reg_bank;

  localparam int W = 8;
  localparam int N = 11;
  localparam int G = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, burst_start, burst_abort, data_valid;
  logic [W-1:0]   data_in;
  logic [N*W-1:0] regs_flat;
  logic           bank_valid, commit_pulse, busy, overflow;
  logic [W-1:0]   scan_data;
  logic [3:0]     scan_idx;
  logic           scan_valid, scan_frame;

  rtc_reg_bank #(.DATA_W(W), .NUM_REGS(N), .SCAN_GAP(G)) dut (
    .clk(clk), .reset(reset), .burst_start(burst_start), .burst_abort(burst_abort),
    .data_in(data_in), .data_valid(data_valid), .regs_flat(regs_flat),
    .bank_valid(bank_valid), .commit_pulse(commit_pulse), .busy(busy), .overflow(overflow),
    .scan_data(scan_data), .scan_idx(scan_idx), .scan_valid(scan_valid), .scan_frame(scan_frame)
  );

  typedef struct {
    logic           busy, ovf, pulse, bv;
    logic [N*W-1:0] flat;
    logic           sv, sf;
    logic [3:0]     sidx;
    logic [W-1:0]   sdata;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Model: capturing flag + word count, pending-commit flag, shadow and visible banks.
  bit         m_cap, m_pend, m_ovf, m_bv;
  int         m_cnt, m_sc;
  logic [W-1:0] m_shadow[N], m_bank[N], m_prev[N];

  task automatic model_step(input bit r, bs, ba, dv, input logic [W-1:0] d);
    if (r) begin
      m_cap = 0; m_pend = 0; m_ovf = 0; m_bv = 0; m_cnt = 0; m_sc = 0;
      for (int k = 0; k < N; k++) begin
        m_shadow[k] = '0; m_bank[k] = '0; m_prev[k] = '0;
      end
      return;
    end
    m_prev = m_bank;
    m_sc++;
    if (ba) begin
      m_cap = 0; m_pend = 0; m_cnt = 0;
      return;
    end
    if (m_pend) begin
      m_bank = m_shadow;
      m_bv = 1;
    end
    if (bs) begin
      m_ovf = 0; m_cap = 1; m_pend = 0; m_cnt = 0;
      if (dv) begin
        m_shadow[0] = d;
        m_cnt = 1;
      end
    end else if (m_pend) begin
      m_pend = 0;
      if (dv) m_ovf = 1;
    end else if (m_cap && dv) begin
      m_shadow[m_cnt] = d;
      m_cnt++;
      if (m_cnt == N) begin
        m_cap = 0; m_pend = 1; m_cnt = 0;
      end
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    int pos;
    e.busy = m_cap | m_pend;
    e.ovf = m_ovf;
    e.pulse = m_pend;
    e.bv = m_bv;
    for (int k = 0; k < N; k++) e.flat[k*W +: W] = m_bank[k];
    e.sv = 0; e.sf = 0; e.sidx = '0; e.sdata = '0;
`ifdef REG_BANK_SCAN_EN
    pos = m_sc % (N + G);
    if (pos >= G) begin
      e.sv = 1;
      e.sf = (pos == G);
      e.sidx = 4'(pos - G);
      e.sdata = m_prev[pos - G];
    end
`else
    pos = 0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("busy", busy, e.busy);
      chk("overflow", overflow, e.ovf);
      chk("commit_pulse", commit_pulse, e.pulse);
      chk("bank_valid", bank_valid, e.bv);
      chk("regs_flat", regs_flat, e.flat);
      chk("scan_valid", scan_valid, e.sv);
      chk("scan_frame", scan_frame, e.sf);
      chk("scan_idx", scan_idx, e.sidx);
      chk("scan_data", scan_data, e.sdata);
    end
  end

  task automatic cyc(input bit r, bs, ba, dv, input logic [W-1:0] d);
    q.push_back(snap());
    reset = r; burst_start = bs; burst_abort = ba; data_valid = dv; data_in = d;
    model_step(r, bs, ba, dv, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    reset = 1; burst_start = 0; burst_abort = 0; data_valid = 0; data_in = '0;
    model_step(1, 0, 0, 0, 8'h00);
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 8'h00);
    idle(14);
    // full burst 0x10..0x1A
    cyc(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < N; i++) cyc(0, 0, 0, 1, 8'(8'h10 + i));
    idle(3);
    // partial burst then abort
    cyc(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8'h55);
    cyc(0, 0, 1, 0, 8'h00);
    idle(2);
    // 12 words: the 12th lands in COMMIT
    cyc(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 8'(8'h30 + i));
    idle(1);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    // start + data together
    cyc(0, 1, 0, 1, 8'hAA);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 8'(8'hA0 + i));
    idle(3);
    // reset mid-burst
    cyc(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'hC3);
    cyc(1, 0, 0, 0, 8'h00);
    idle(20);
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
    end
    idle(4);
    repeat (3) @(posedge clk);
    chk("queue_drained", 128'(q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
